mmio_bus_controller: RTL
========================

MMIO_BUS_CONTROLLER -- requirements
Module: mmio_bus_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, meaning max DEV_WAIT cycles before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mem_req_valid  in  1  MEM-stage load/store present.
REQ-005 mem_we  in  1  1=store, 0=load.
REQ-006 mem_addr  in  32  byte address.
REQ-007 mem_wdata  in  32  store data.
REQ-008 mem_stall  out  1  hold pipeline.
REQ-009 mem_rdata  out  32  load data, valid when mem_rdata_valid=1.
REQ-010 mem_rdata_valid  out  1  one-cycle completion pulse (loads and stores).
REQ-011 bus_err  out  1  one-cycle pulse with mem_rdata_valid on unmapped or timed-out access.
REQ-012 err_addr  out  32  address of most recent errored access.
REQ-013 dev_sel  out  6  one-hot {num_buf,vga,ps2,led,uart,bram}, bit0=bram.
REQ-014 dev_req  out  1  device request strobe (non-BRAM).
REQ-015 dev_we, dev_addr[31:0], dev_wdata[31:0]  out  latched request fields.
REQ-016 dev_ack  in  1  device completion; dev_rdata[31:0] in, externally muxed by dev_sel.

Function
REQ-017 Decode addr[31:28]: 0=bram, 1=uart, 2=led, 3=ps2, 4=vga, 5=num_buf, 6..F=unmapped.
REQ-018 States: IDLE, BRAM_WAIT, DEV_WAIT, RESP.
REQ-019 IDLE + mem_req_valid: latch we/addr/wdata/dev_sel; go BRAM_WAIT if bram, DEV_WAIT if device, RESP with error if unmapped.
REQ-020 mem_stall = 1 in IDLE when mem_req_valid=1 (combinational), 1 in BRAM_WAIT and DEV_WAIT, 0 in RESP and in idle IDLE.
REQ-021 BRAM_WAIT lasts exactly one cycle, no ack used; capture dev_rdata at its end; go RESP.
REQ-022 DEV_WAIT: dev_req=1 from the first DEV_WAIT cycle until the cycle dev_ack is sampled high; dev_req=0 in all other states.
REQ-023 DEV_WAIT + dev_ack: capture dev_rdata (loads) into mem_rdata; go RESP with no error.
REQ-024 Wait counter, 8 bits, cleared on DEV_WAIT entry, incremented each DEV_WAIT cycle without ack; on count reaching TIMEOUT_CYCLES with no ack: go RESP with error.
REQ-025 dev_ack high in the same cycle the timeout is reached: ack wins, no error.
REQ-026 RESP lasts one cycle: mem_rdata_valid=1; bus_err per REQ-019/024; mem_req_valid ignored; next state IDLE.
REQ-027 Errored access: mem_rdata=0, err_addr updated with latched address, stores discarded, no dev_req issued for unmapped.
REQ-028 mem_rdata holds its value until the next capture; stores leave mem_rdata unchanged.
REQ-029 dev_sel, dev_addr, dev_we, dev_wdata stay stable from latch until the next IDLE acceptance.
REQ-030 dev_ack while not in DEV_WAIT is ignored.
REQ-031 Back-to-back: a new request is accepted in the IDLE cycle directly after RESP (minimum 3 cycles per BRAM access).

Reset
REQ-032 rst low, asynchronously: state=IDLE, counter=0, mem_rdata=0, err_addr=0, dev_sel=0, dev_addr=0, dev_wdata=0, dev_we=0, dev_req=0, mem_rdata_valid=0, bus_err=0; mem_stall=0 while rst low.
REQ-033 Reset mid-transaction abandons the access; no completion pulse follows reset release.

Verification
REQ-034 BRAM load addr 0x00000040, dev_rdata=0x12345678 -> stall cycles 0-1, cycle 2 mem_rdata_valid=1, mem_rdata=0x12345678, dev_req never high.
REQ-035 LED store addr 0x20000000 data 0xA5, dev_ack on 3rd DEV_WAIT cycle -> dev_sel=6'b000100, dev_req high 3 cycles, dev_wdata=0xA5, one valid pulse, bus_err=0.
REQ-036 UART load 0x10000004, no ack, TIMEOUT_CYCLES=15 -> dev_req high 15 cycles, then valid=1, bus_err=1, mem_rdata=0, err_addr=0x10000004.
REQ-037 Load 0x70000000 -> no dev_req, next cycle valid=1 bus_err=1, err_addr=0x70000000; ack exactly at timeout count on PS2 read -> bus_err=0, data captured.
REQ-038 rst low during DEV_WAIT -> all outputs to REQ-032 values immediately; after release, no valid pulse until a new request.

Source files
------------

// File: rtl/mmio_bus_controller_if.sv
// Bundles the MEM-stage request/response signals and the device-side bus.
// master: the controller's view; slave: the pipeline/device environment's view.
interface mmio_bus_controller_if;
  logic        mem_req_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [5:0]  dev_sel;
  logic        dev_req;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  modport master (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, dev_ack, dev_rdata,
    output mem_stall, mem_rdata, mem_rdata_valid, bus_err, err_addr,
           dev_sel, dev_req, dev_we, dev_addr, dev_wdata
  );

  modport slave (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, dev_ack, dev_rdata,
    input  mem_stall, mem_rdata, mem_rdata_valid, bus_err, err_addr,
           dev_sel, dev_req, dev_we, dev_addr, dev_wdata
  );
endinterface

// File: rtl/mmio_bus_controller.sv
// Decodes MEM-stage accesses onto BRAM or one of five MMIO devices, stalling the pipeline
// until BRAM data arrives, the device acks, the wait times out, or the address is unmapped.
module mmio_bus_controller #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  mmio_bus_controller_if.master bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BRAM_WAIT = 2'd1;
  localparam logic [1:0] DEV_WAIT  = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       err;
  logic [3:0] region;
  logic [5:0] sel_dec;
  logic       accept;

  assign region = bus.mem_addr[31:28];
  assign accept = (state == IDLE) && bus.mem_req_valid;

  always_comb begin
    sel_dec = 6'b000000;
    if (region < 4'd6) sel_dec = 6'b000001 << region;
  end

  // Gate with rst_n so a request held during reset does not show as a stall.
  assign bus.mem_stall       = rst_n && (accept || (state == BRAM_WAIT) || (state == DEV_WAIT));
  assign bus.dev_req         = (state == DEV_WAIT);
  assign bus.mem_rdata_valid = (state == RESP);
  assign bus.bus_err         = (state == RESP) && err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      err           <= 1'b0;
      bus.mem_rdata <= 32'd0;
      bus.err_addr  <= 32'd0;
      bus.dev_sel   <= 6'd0;
      bus.dev_addr  <= 32'd0;
      bus.dev_wdata <= 32'd0;
      bus.dev_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req_valid) begin
            bus.dev_we    <= bus.mem_we;
            bus.dev_addr  <= bus.mem_addr;
            bus.dev_wdata <= bus.mem_wdata;
            bus.dev_sel   <= sel_dec;
            wait_cnt      <= 8'd0;
            if (sel_dec == 6'd0) begin
              err           <= 1'b1;
              bus.mem_rdata <= 32'd0;
              bus.err_addr  <= bus.mem_addr;
              state         <= RESP;
            end else begin
              err   <= 1'b0;
              state <= sel_dec[0] ? BRAM_WAIT : DEV_WAIT;
            end
          end
        end
        BRAM_WAIT: begin
          if (!bus.dev_we) bus.mem_rdata <= bus.dev_rdata;
          state <= RESP;
        end
        DEV_WAIT: begin
          // An ack arriving on the final wait cycle still completes cleanly.
          if (bus.dev_ack) begin
            if (!bus.dev_we) bus.mem_rdata <= bus.dev_rdata;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              err           <= 1'b1;
              bus.mem_rdata <= 32'd0;
              bus.err_addr  <= bus.dev_addr;
              state         <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
